// File: rtl/codec_config_sequencer_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer.
// The boot table is a constant function so the sequencer needs no ROM instance.
package codec_cfg_pkg;

   localparam int REG_W     = 7;
   localparam int DATA_W    = 9;
   localparam int PAYLOAD_W = 8;
   localparam int IDX_W     = 3;

   localparam logic [IDX_W-1:0] USER_FAIL_IDX = 3'd7;

   localparam logic [REG_W-1:0] REG_RESET   = 7'h0F;
   localparam logic [REG_W-1:0] REG_PWR     = 7'h06;
   localparam logic [REG_W-1:0] REG_DIGPATH = 7'h05;
   localparam logic [REG_W-1:0] REG_ANAPATH = 7'h04;
   localparam logic [REG_W-1:0] REG_IFACE   = 7'h07;
   localparam logic [REG_W-1:0] REG_ACTIVE  = 7'h09;

   typedef enum logic [2:0] {
      ST_BOOT_LOAD,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_RELEASE,
      ST_RETRY,
      ST_IDLE_READY,
      ST_USER_LOAD,
      ST_ERROR
   } state_e;

   // Returns {reg[6:0], data[8:0]}; slots past the programmed table read as zero.
   function automatic logic [REG_W+DATA_W-1:0] boot_rom(input logic [IDX_W-1:0] idx);
      logic [REG_W+DATA_W-1:0] word;
      case (idx)
         3'd0:    word = {REG_RESET,   9'h000};
         3'd1:    word = {REG_PWR,     9'h000};
         3'd2:    word = {REG_DIGPATH, 9'h006};
         3'd3:    word = {REG_ANAPATH, 9'h038};
         3'd4:    word = {REG_IFACE,   9'h04A};
         3'd5:    word = {REG_ACTIVE,  9'h001};
         default: word = '0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/codec_config_sequencer_if.sv
// Bundles for the i2c_write engine handshake and the single run-time requester.
// master drives the request side, slave answers with done/ack.
interface codec_cfg_i2c_if;
   import codec_cfg_pkg::*;

   logic                 i2c_write;
   logic [PAYLOAD_W-1:0] i2c_register;
   logic [PAYLOAD_W-1:0] i2c_data;
   logic                 i2c_done;

   modport master (output i2c_write, output i2c_register, output i2c_data, input i2c_done);
   modport slave  (input i2c_write, input i2c_register, input i2c_data, output i2c_done);
endinterface

interface codec_cfg_user_if;
   import codec_cfg_pkg::*;

   logic              user_req;
   logic [REG_W-1:0]  user_reg;
   logic [DATA_W-1:0] user_data;
   logic              user_ack;

   modport master (output user_req, output user_reg, output user_data, input user_ack);
   modport slave  (input user_req, input user_reg, input user_data, output user_ack);
endinterface

// File: rtl/codec_config_sequencer.sv
// Walks the WM8731 boot table over the shared i2c_write engine, then serves user writes.
// Four-phase write/done per write; timeout triggers bounded retries, then sticky error.
module codec_config_sequencer
   import codec_cfg_pkg::*;
#(
   parameter int NUM_ENTRIES    = 6,
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int MAX_RETRY      = 2
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             start,
   codec_cfg_user_if.slave  usr,
   codec_cfg_i2c_if.master  i2c,
   output logic             busy,
   output logic             config_done,
   output logic             error,
   output logic [IDX_W-1:0] fail_index
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_SAT  = {TMR_W{1'b1}};
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_e               state_q,     state_d;
   logic [IDX_W-1:0]     idx_q,       idx_d;
   logic [RTY_W-1:0]     retry_q,     retry_d;
   logic [TMR_W-1:0]     timer_q,     timer_d;
   logic                 user_mode_q, user_mode_d;
   logic                 write_q,     write_d;
   logic [PAYLOAD_W-1:0] reg_byte_q,  reg_byte_d;
   logic [PAYLOAD_W-1:0] data_byte_q, data_byte_d;
   logic                 ack_q,       ack_d;
   logic                 cfg_done_q,  cfg_done_d;
   logic                 error_q,     error_d;
   logic [IDX_W-1:0]     fail_idx_q,  fail_idx_d;
   logic                 busy_q,      busy_d;

   logic [REG_W+DATA_W-1:0] rom_word;

   assign rom_word = boot_rom(idx_q);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q     <= ST_BOOT_LOAD;
         idx_q       <= '0;
         retry_q     <= '0;
         timer_q     <= '0;
         user_mode_q <= 1'b0;
         write_q     <= 1'b0;
         reg_byte_q  <= '0;
         data_byte_q <= '0;
         ack_q       <= 1'b0;
         cfg_done_q  <= 1'b0;
         error_q     <= 1'b0;
         fail_idx_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         user_mode_q <= user_mode_d;
         write_q     <= write_d;
         reg_byte_q  <= reg_byte_d;
         data_byte_q <= data_byte_d;
         ack_q       <= ack_d;
         cfg_done_q  <= cfg_done_d;
         error_q     <= error_d;
         fail_idx_q  <= fail_idx_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      retry_d     = retry_q;
      timer_d     = timer_q;
      user_mode_d = user_mode_q;
      write_d     = 1'b0;
      reg_byte_d  = reg_byte_q;
      data_byte_d = data_byte_q;
      ack_d       = 1'b0;
      cfg_done_d  = cfg_done_q;
      error_d     = error_q;
      fail_idx_d  = fail_idx_q;

      if (start) begin
         state_d     = ST_BOOT_LOAD;
         idx_d       = '0;
         retry_d     = '0;
         timer_d     = '0;
         user_mode_d = 1'b0;
         cfg_done_d  = 1'b0;
         error_d     = 1'b0;
         fail_idx_d  = '0;
      end else begin
         case (state_q)
            ST_BOOT_LOAD: begin
               if (!i2c.i2c_done) begin
                  reg_byte_d  = {rom_word[REG_W+DATA_W-1:DATA_W], rom_word[DATA_W-1]};
                  data_byte_d = rom_word[PAYLOAD_W-1:0];
                  user_mode_d = 1'b0;
                  state_d     = ST_ISSUE;
               end
            end
            ST_USER_LOAD: begin
               if (!i2c.i2c_done) begin
                  reg_byte_d  = {usr.user_reg, usr.user_data[DATA_W-1]};
                  data_byte_d = usr.user_data[PAYLOAD_W-1:0];
                  state_d     = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer_d = '0;
               // write is registered, so holding here keeps it from rising into a high done
               if (!i2c.i2c_done) begin
                  write_d = 1'b1;
                  state_d = ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (i2c.i2c_done) begin
                  state_d = ST_RELEASE;
               end else if (timer_q == TMR_LAST) begin
                  state_d = ST_RETRY;
               end else begin
                  write_d = 1'b1;
                  if (timer_q != TMR_SAT) begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end
            ST_RELEASE: begin
               if (!i2c.i2c_done) begin
                  if (user_mode_q) begin
                     ack_d   = 1'b1;
                     state_d = ST_IDLE_READY;
                  end else if (idx_q == LAST_IDX) begin
                     cfg_done_d = 1'b1;
                     state_d    = ST_IDLE_READY;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     retry_d = '0;
                     state_d = ST_BOOT_LOAD;
                  end
               end
            end
            ST_RETRY: begin
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = user_mode_q ? ST_USER_LOAD : ST_BOOT_LOAD;
               end else begin
                  error_d    = 1'b1;
                  fail_idx_d = user_mode_q ? USER_FAIL_IDX : idx_q;
                  state_d    = ST_ERROR;
               end
            end
            ST_IDLE_READY: begin
               // the requester still holds user_req in the ack cycle; do not serve it twice
               if (usr.user_req && !ack_q) begin
                  user_mode_d = 1'b1;
                  retry_d     = '0;
                  state_d     = ST_USER_LOAD;
               end
            end
            ST_ERROR: begin
               state_d = ST_ERROR;
            end
            default: begin
               state_d = ST_ERROR;
            end
         endcase
      end

      busy_d = !((state_d == ST_IDLE_READY) || (state_d == ST_ERROR));
   end

   assign i2c.i2c_write    = write_q;
   assign i2c.i2c_register = reg_byte_q;
   assign i2c.i2c_data     = data_byte_q;
   assign usr.user_ack     = ack_q;
   assign busy             = busy_q;
   assign config_done      = cfg_done_q;
   assign error            = error_q;
   assign fail_index       = fail_idx_q;

endmodule
